// File: rtl/alu_sequencer.sv
// Purpose: sequences one accumulator op at a time through a shared 11-bit signed ALU, saturating writeback to +/-MAX_VAL.
// Latency: accept cycle -> done cycle is 3 cycles (SETUP, EXEC, done); an illegal op gets done+err in the following cycle.
// Backpressure: cmd_ready is high only in IDLE (including the done cycle), so a command can be accepted every 3 cycles.
module alu_sequencer #(
  parameter int MAX_VAL  = 999,
  parameter int NOT_TRUE = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic signed [10:0] cmd_operand,
  output logic signed [10:0] alu_in0,
  output logic signed [10:0] alu_in1,
  output logic [3:0]         alu_funct,
  input  logic signed [10:0] alu_out,
  input  logic               alu_overflow,
  input  logic               alu_gr,
  input  logic               alu_le,
  input  logic               alu_eq,
  output logic signed [10:0] acc,
  output logic               plus_en,
  output logic               minus_en,
  output logic               done,
  output logic               sat,
  output logic               err
);

  localparam logic signed [10:0] MAX_S = 11'(MAX_VAL);
  localparam logic signed [10:0] MIN_S = -MAX_S;
  localparam logic signed [10:0] NOT_S = 11'(NOT_TRUE);

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_TEQ = 4'b1100;
  localparam logic [3:0] OP_TGT = 4'b1101;
  localparam logic [3:0] OP_TLT = 4'b1110;
  localparam logic [3:0] OP_TCP = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EXEC} state_t;

  state_t     state, state_nxt;
  logic [3:0] op_q;

  logic signed [10:0] wb_raw;
  logic signed [10:0] wb_val;
  logic               wb_sat;
  logic               ovf_neg;

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v);
    if (v > MAX_S)      return MAX_S;
    else if (v < MIN_S) return MIN_S;
    else                return v;
  endfunction

  // State register; reset aborts any in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake and ALU function select. funct stays 0000 until
  // EXEC so the ALU sees stable operands before its funct change.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    alu_funct = 4'b0000;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_op[3]) state_nxt = S_SETUP;
      end
      S_SETUP: state_nxt = S_EXEC;
      S_EXEC: begin
        alu_funct = op_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Arithmetic writeback value: on ALU overflow pick the rail from the true
  // sign of the result, then clamp to the accumulator range.
  always_comb begin
    ovf_neg = (op_q == OP_MUL) ? (alu_in0[10] ^ alu_in1[10]) : alu_in0[10];
    wb_raw  = alu_out;
    if (alu_overflow) wb_raw = ovf_neg ? MIN_S : MAX_S;
    wb_val  = clamp(wb_raw);
    wb_sat  = alu_overflow || (wb_val != wb_raw);
  end

  // Operand capture, accumulator/enable writeback and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= 4'b0000;
      alu_in0  <= '0;
      alu_in1  <= '0;
      acc      <= '0;
      plus_en  <= 1'b0;
      minus_en <= 1'b0;
      done     <= 1'b0;
      sat      <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      sat  <= 1'b0;
      err  <= 1'b0;
      if (state == S_IDLE && cmd_valid) begin
        if (cmd_op[3]) begin
          op_q    <= cmd_op;
          alu_in0 <= acc;
          alu_in1 <= clamp(cmd_operand);
        end else begin
          done <= 1'b1;
          err  <= 1'b1;
        end
      end
      if (state == S_EXEC) begin
        done <= 1'b1;
        case (op_q)
          OP_ADD, OP_SUB, OP_MUL: begin
            acc <= wb_val;
            sat <= wb_sat;
          end
          OP_NOT: acc <= (alu_out != 11'sd0) ? NOT_S : 11'sd0;
          OP_TEQ: begin
            plus_en  <= alu_eq;
            minus_en <= !alu_eq;
          end
          OP_TGT: begin
            plus_en  <= alu_gr;
            minus_en <= !alu_gr;
          end
          OP_TLT: begin
            plus_en  <= alu_le;
            minus_en <= !alu_le;
          end
          OP_TCP: begin
            plus_en  <= alu_gr;
            minus_en <= alu_le;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: scoreboard bench for alu_sequencer with a behavioural 11-bit signed ALU.
// Latency: expects done 3 cycles after the accept cycle (1 for illegal ops).
// Backpressure: driver holds cmd_valid until cmd_ready, issuing back-to-back where possible.
module tb_alu_sequencer;

  localparam logic [3:0] OP_ILL = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_TEQ = 4'b1100;
  localparam logic [3:0] OP_TGT = 4'b1101;
  localparam logic [3:0] OP_TLT = 4'b1110;
  localparam logic [3:0] OP_TCP = 4'b1111;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_op;
  logic signed [10:0] cmd_operand;
  logic signed [10:0] alu_in0, alu_in1;
  logic [3:0]         alu_funct;
  logic signed [10:0] alu_out;
  logic               alu_overflow, alu_gr, alu_le, alu_eq;
  logic signed [10:0] acc;
  logic               plus_en, minus_en, done, sat, err;

  typedef struct {
    int acc;
    int p;
    int m;
    int s;
    int e;
    int lat;
    int cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_a, m_b, m_s;

  alu_sequencer #(.MAX_VAL(999), .NOT_TRUE(100)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_funct(alu_funct),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .alu_gr(alu_gr), .alu_le(alu_le), .alu_eq(alu_eq),
    .acc(acc), .plus_en(plus_en), .minus_en(minus_en),
    .done(done), .sat(sat), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared ALU: wraps to 11 bits, flags signed overflow.
  always_comb begin
    m_a = int'(alu_in0);
    m_b = int'(alu_in1);
    m_s = 0;
    case (alu_funct)
      OP_ADD:  m_s = m_a + m_b;
      OP_SUB:  m_s = m_a - m_b;
      OP_MUL:  m_s = m_a * m_b;
      OP_NOT:  m_s = (m_a == 0) ? 1 : 0;
      default: m_s = 0;
    endcase
    alu_out      = m_s[10:0];
    alu_overflow = (alu_funct == OP_ADD || alu_funct == OP_SUB || alu_funct == OP_MUL) &&
                   (m_s > 1023 || m_s < -1024);
    alu_gr = (m_a > m_b);
    alu_le = (m_a < m_b);
    alu_eq = (m_a == m_b);
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        chk({mon_nm, " acc"}, int'(acc), mon_e.acc);
        chk({mon_nm, " plus_en"}, int'(plus_en), mon_e.p);
        chk({mon_nm, " minus_en"}, int'(minus_en), mon_e.m);
        chk({mon_nm, " sat"}, int'(sat), mon_e.s);
        chk({mon_nm, " err"}, int'(err), mon_e.e);
        chk({mon_nm, " latency"}, cyc - mon_e.cyc, mon_e.lat);
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input int opnd,
                       input int eacc, input int ep, input int em, input int es, input int ee);
    int   guard;
    exp_t e;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = 11'(opnd);
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk({nm, " accept_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e.acc = eacc; e.p = ep; e.m = em; e.s = es; e.e = ee;
    e.lat = op[3] ? 3 : 1;
    e.cyc = cyc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, " acc"}, int'(acc), 0);
    chk({nm, " plus_en"}, int'(plus_en), 0);
    chk({nm, " minus_en"}, int'(minus_en), 0);
    chk({nm, " cmd_ready"}, int'(cmd_ready), 1);
    chk({nm, " alu_funct"}, int'(alu_funct), 0);
    chk({nm, " alu_in0"}, int'(alu_in0), 0);
    chk({nm, " alu_in1"}, int'(alu_in1), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " sat"}, int'(sat), 0);
    chk({nm, " err"}, int'(err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 4'b0000;
    cmd_operand = '0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset_released");

    // Accumulate and saturate; back-to-back issue exercises the 3-cycle cadence.
    issue("add500",  OP_ADD, 500, 500, 0, 0, 0, 0);
    issue("add600",  OP_ADD, 600, 999, 0, 0, 1, 0);
    issue("add20",   OP_ADD, 20,  999, 0, 0, 1, 0);
    drain();

    // Subtract down to the negative rail; 1023 is the largest presentable
    // operand and must be clamped to 999 at capture.
    do_reset();
    issue("sub999a", OP_SUB, 999,   -999, 0, 0, 0, 0);
    issue("sub999b", OP_SUB, 999,   -999, 0, 0, 1, 0);
    issue("add1023", OP_ADD, 1023,  0,    0, 0, 0, 0);
    issue("addm1024", OP_ADD, -1024, -999, 0, 0, 0, 0);
    issue("add999",  OP_ADD, 999,   0,    0, 0, 0, 0);
    issue("add40",   OP_ADD, 40,    40,   0, 0, 0, 0);
    issue("mul30",   OP_MUL, 30,    999,  0, 0, 1, 0);
    issue("mulm1",   OP_MUL, -1,    -999, 0, 0, 0, 0);
    issue("not_a",   OP_NOT, 0,     0,    0, 0, 0, 0);
    issue("not_b",   OP_NOT, 0,     100,  0, 0, 0, 0);
    drain();

    // Conditional-execute enables from acc=5.
    do_reset();
    issue("add5",    OP_ADD, 5, 5, 0, 0, 0, 0);
    issue("tcp5",    OP_TCP, 5, 5, 0, 0, 0, 0);
    issue("tcp3",    OP_TCP, 3, 5, 1, 0, 0, 0);
    issue("tlt9",    OP_TLT, 9, 5, 1, 0, 0, 0);
    issue("teq4",    OP_TEQ, 4, 5, 0, 1, 0, 0);
    issue("tgt2",    OP_TGT, 2, 5, 1, 0, 0, 0);
    issue("tcp9",    OP_TCP, 9, 5, 0, 1, 0, 0);
    issue("add1",    OP_ADD, 1, 6, 0, 1, 0, 0);
    issue("illegal", OP_ILL, 7, 6, 0, 1, 0, 1);
    issue("tgt10",   OP_TGT, 10, 6, 0, 1, 0, 0);
    drain();

    // Asynchronous reset during EXEC of ADD 7: no writeback, no done.
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = OP_ADD;
    cmd_operand = 11'sd7;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("exec_reached alu_funct", int'(alu_funct), int'(OP_ADD));
    #2 reset = 1'b1;
    #1 chk("async_reset acc", int'(acc), 0);
    chk("async_reset alu_funct", int'(alu_funct), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check_idle("after_abort");

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
